mem_arbiter: RTL and testbench

//  Shares the single-port syncram between the instruction-fetch port (read-only)
//  and the load/store data port (read/write) of the MIPS core. Arbitrates,

---
 rtl/mem_arbiter.sv | 163 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port syncram between the instruction-fetch
// port (read-only) and the load/store data port (read/write).
// Each access is sequenced as IDLE -> ACCESS -> WAIT (reads only) -> RESP.
// The read word is captured from the syncram and returned together with a
// one-cycle ack on the port that was granted.
//
// Handshake: a requester raises req with its address and data and holds all of
// them until the matching ack pulse. Everything the memory needs is latched at
// grant, so the request inputs are ignored from the grant edge onward. The
// requester drops req, or presents a new request, in the cycle after ack. Only
// one ack is high in any cycle. A request that is not granted keeps waiting in
// IDLE until it wins.
module mem_arbiter #(
    parameter int RD_LAT    = 1,    // cycles after the access edge until mem_dout is valid (>=1)
    parameter bit DATA_PRIO = 1'b0  // 0 = round-robin on conflict, 1 = data port always wins
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ack,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic        d_err,
    output logic        mem_cs,
    output logic        mem_oe,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    input  logic [31:0] mem_dout,
    output logic        busy,
    output logic [1:0]  dbg_state
);

    localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t        state;
    logic          last_data;  // most recent grant went to the data port
    logic          gnt_data;   // current access belongs to the data port
    logic          gnt_we;     // current access is a store
    logic [CW-1:0] lat_cnt;    // WAIT cycles left before the capture edge
    logic          win_data;   // data port wins if granted this cycle
    logic          d_misal;    // data address is not word aligned

    // Winner selection. On a conflict the data port wins if it has priority,
    // and otherwise wins only if fetch was served last.
    always_comb begin
        win_data = 1'b0;
        d_misal  = 1'b0;
        win_data = d_req && (!i_req || DATA_PRIO || !last_data);
        d_misal  = (d_addr[1:0] != 2'b00);
    end

    assign busy      = (state != ST_IDLE);
    assign dbg_state = state;

    // Access sequencer. All outputs are registered. mem_addr and mem_din act
    // as the grant-time latches and keep their last value between accesses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            last_data <= 1'b0;
            gnt_data  <= 1'b0;
            gnt_we    <= 1'b0;
            lat_cnt   <= '0;
            i_rdata   <= '0;
            i_ack     <= 1'b0;
            d_rdata   <= '0;
            d_ack     <= 1'b0;
            d_err     <= 1'b0;
            mem_cs    <= 1'b0;
            mem_oe    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_din   <= '0;
        end else begin
            i_ack   <= 1'b0;
            d_ack   <= 1'b0;
            d_err   <= 1'b0;
            i_rdata <= '0;
            d_rdata <= '0;
            mem_cs  <= 1'b0;
            mem_oe  <= 1'b0;
            mem_we  <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (i_req || d_req) begin
                        gnt_data  <= win_data;
                        last_data <= win_data;
                        if (win_data && d_misal) begin
                            // Misaligned data access: reject at once, memory untouched.
                            gnt_we <= d_we;
                            state  <= ST_RESP;
                            d_ack  <= 1'b1;
                            d_err  <= 1'b1;
                        end else if (win_data) begin
                            gnt_we   <= d_we;
                            state    <= ST_ACCESS;
                            mem_cs   <= 1'b1;
                            mem_addr <= d_addr;
                            mem_oe   <= !d_we;
                            mem_we   <= d_we;
                            if (d_we) begin
                                mem_din <= d_wdata;
                            end
                        end else begin
                            gnt_we   <= 1'b0;
                            state    <= ST_ACCESS;
                            mem_cs   <= 1'b1;
                            mem_addr <= i_addr;
                            mem_oe   <= 1'b1;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (gnt_we) begin
                        state <= ST_RESP;
                        d_ack <= 1'b1;
                    end else begin
                        state   <= ST_WAIT;
                        mem_oe  <= 1'b1;
                        lat_cnt <= CW'(RD_LAT - 1);
                    end
                end
                ST_WAIT: begin
                    if (lat_cnt == '0) begin
                        // Final WAIT edge: mem_dout is valid now.
                        state <= ST_RESP;
                        if (gnt_data) begin
                            d_ack   <= 1'b1;
                            d_rdata <= mem_dout;
                        end else begin
                            i_ack   <= 1'b1;
                            i_rdata <= mem_dout;
                        end
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                        mem_oe  <= 1'b1;
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter. It builds two instances: inst0 uses RD_LAT=1 with
// round-robin arbitration, and inst1 uses RD_LAT=3 with data priority. Each
// instance has its own syncram model. A reference memory and an expected-ack
// queue hold what every completion must return.
module tb_mem_arbiter;

    logic             clk;
    logic             rst;
    logic [1:0]       i_req;
    logic [1:0][31:0] i_addr;
    logic [1:0][31:0] i_rdata;
    logic [1:0]       i_ack;
    logic [1:0]       d_req;
    logic [1:0]       d_we;
    logic [1:0][31:0] d_addr;
    logic [1:0][31:0] d_wdata;
    logic [1:0][31:0] d_rdata;
    logic [1:0]       d_ack;
    logic [1:0]       d_err;
    logic [1:0]       mem_cs;
    logic [1:0]       mem_oe;
    logic [1:0]       mem_we;
    logic [1:0][31:0] mem_addr;
    logic [1:0][31:0] mem_din;
    logic [1:0][31:0] mem_dout;
    logic [1:0]       busy;
    logic [1:0][1:0]  dbg_state;

    int unsigned cyc;
    int          n_cmp;
    int          n_bad;
    int          cs_cnt [2];
    int          we_cnt [2];

    // Expected completion: {is_data, err, check_data, data}
    logic [34:0] exp_q0 [$];
    logic [34:0] exp_q1 [$];
    logic [31:0] ref_mem [2][256];

    function automatic logic [31:0] init_word(input logic [7:0] i);
        return (i == 8'h14) ? 32'hAABBCCDD : {16'hC0DE, 8'h00, i};
    endfunction

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUTs and syncram models ----------------
    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int LAT = (g == 0) ? 1 : 3;
        logic [31:0] ram [256];
        logic [31:0] pipe [3];
        logic [7:0]  idx;
        assign idx         = mem_addr[g][9:2];
        assign mem_dout[g] = pipe[LAT-1];

        mem_arbiter #(.RD_LAT(LAT), .DATA_PRIO(g == 0 ? 1'b0 : 1'b1)) u_dut (
            .clk(clk), .rst(rst),
            .i_req(i_req[g]), .i_addr(i_addr[g]), .i_rdata(i_rdata[g]), .i_ack(i_ack[g]),
            .d_req(d_req[g]), .d_we(d_we[g]), .d_addr(d_addr[g]), .d_wdata(d_wdata[g]),
            .d_rdata(d_rdata[g]), .d_ack(d_ack[g]), .d_err(d_err[g]),
            .mem_cs(mem_cs[g]), .mem_oe(mem_oe[g]), .mem_we(mem_we[g]),
            .mem_addr(mem_addr[g]), .mem_din(mem_din[g]), .mem_dout(mem_dout[g]),
            .busy(busy[g]), .dbg_state(dbg_state[g])
        );

        // Syncram model: dout valid LAT cycles after the access edge; junk otherwise.
        always @(posedge clk) begin
            if (rst) begin
                for (int i = 0; i < 256; i++) ram[i] <= init_word(8'(i));
            end else if (mem_cs[g] && mem_we[g]) begin
                ram[idx] <= mem_din[g];
            end
            pipe[0] <= (mem_cs[g] && mem_oe[g] && !mem_we[g]) ? ram[idx] : {16'hBAD0, cyc[15:0]};
            pipe[1] <= pipe[0];
            pipe[2] <= pipe[1];
        end
    end

    // ---------------- scoreboard helpers ----------------
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic ref_reset();
        for (int g = 0; g < 2; g++)
            for (int i = 0; i < 256; i++) ref_mem[g][i] = init_word(8'(i));
    endtask

    function automatic logic [34:0] exp_rd(input int g, input bit pd, input logic [31:0] addr);
        return {pd, 1'b0, 1'b1, ref_mem[g][addr[9:2]]};
    endfunction

    task automatic push_exp(input int g, input logic [34:0] e);
        if (g == 0) exp_q0.push_back(e);
        else        exp_q1.push_back(e);
    endtask

    // ---------------- compare process ----------------
    initial begin
        forever begin
            @(negedge clk);
            for (int g = 0; g < 2; g++) begin
                if (rst) begin
                    chk($sformatf("rst_outs_g%0d", g),
                        64'({i_ack[g], d_ack[g], d_err[g], mem_cs[g], mem_oe[g], mem_we[g], busy[g]}), 64'd0);
                    chk($sformatf("rst_data_g%0d", g),
                        64'(i_rdata[g] | d_rdata[g] | mem_addr[g] | mem_din[g]), 64'd0);
                end else begin
                    logic [34:0] e;
                    logic [34:0] act;
                    chk($sformatf("ack_excl_g%0d", g), 64'(i_ack[g] & d_ack[g]), 64'd0);
                    if (!busy[g]) chk($sformatf("idle_mem_g%0d", g), 64'({mem_cs[g], mem_oe[g], mem_we[g]}), 64'd0);
                    if (mem_cs[g]) chk($sformatf("cs_oe_we_g%0d", g), 64'(mem_oe[g] ^ mem_we[g]), 64'd1);
                    if (d_err[g]) chk($sformatf("err_wo_ack_g%0d", g), 64'(d_ack[g]), 64'd1);
                    if (mem_cs[g]) cs_cnt[g]++;
                    if (mem_cs[g] && mem_we[g]) we_cnt[g]++;
                    if (i_ack[g] || d_ack[g]) begin
                        n_cmp++;
                        if ((g == 0 && exp_q0.size() == 0) || (g == 1 && exp_q1.size() == 0)) begin
                            n_bad++;
                            $display("FAIL unexpected_ack_g%0d: got i_ack=%0b d_ack=%0b expected none (t=%0t)",
                                     g, i_ack[g], d_ack[g], $time);
                        end else begin
                            e   = (g == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                            act = {d_ack[g], d_err[g], e[32],
                                   e[32] ? (d_ack[g] ? d_rdata[g] : i_rdata[g]) : 32'h0};
                            n_cmp--;
                            chk($sformatf("ack_g%0d", g), 64'(act), 64'(e));
                        end
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // One isolated transaction. exp_lat counts edges from grant to the edge
    // that samples ack high. The request inputs are scrambled right after grant.
    task automatic xact(input string nm, input int g, input bit pd, input bit we,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input int exp_lat, input int exp_cs, input int exp_we);
        bit err;
        bit got;
        int n;
        int cs0;
        int we0;
        err = pd && (addr[1:0] != 2'b00);
        push_exp(g, {pd, err, (!err && !we), (!err && !we) ? ref_mem[g][addr[9:2]] : 32'h0});
        if (!err && we) ref_mem[g][addr[9:2]] = wd;
        cs0 = cs_cnt[g];
        we0 = we_cnt[g];
        @(posedge clk); #1;
        if (pd) begin
            d_req[g] = 1'b1; d_we[g] = we; d_addr[g] = addr; d_wdata[g] = wd;
        end else begin
            i_req[g] = 1'b1; i_addr[g] = addr;
        end
        n = 0;
        got = 1'b0;
        while (!got && n < 30) begin
            @(posedge clk); #1;
            n++;
            got = pd ? d_ack[g] : i_ack[g];
            if (n == 1) begin
                d_addr[g]  = d_addr[g] ^ 32'h0000_0FF0;
                d_wdata[g] = ~d_wdata[g];
                i_addr[g]  = i_addr[g] ^ 32'h0000_0FF0;
            end
        end
        i_req[g] = 1'b0;
        d_req[g] = 1'b0;
        d_we[g]  = 1'b0;
        if (!got) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: got no ack after %0d cycles expected ack at %0d", nm, n, exp_lat);
        end else begin
            chk({nm, "_lat"}, 64'(n), 64'(exp_lat));
        end
        @(posedge clk); #1;
        chk({nm, "_cs"}, 64'(cs_cnt[g] - cs0), 64'(exp_cs));
        chk({nm, "_we"}, 64'(we_cnt[g] - we0), 64'(exp_we));
    endtask

    // Back-to-back reads on one port: req stays high and the address advances after each ack.
    task automatic stream(input int g, input bit pd, input logic [31:0] base, input int cnt);
        for (int k = 0; k < cnt; k++) begin
            bit got;
            int n;
            if (pd) begin
                d_req[g] = 1'b1; d_we[g] = 1'b0; d_addr[g] = base + 32'(4 * k);
            end else begin
                i_req[g] = 1'b1; i_addr[g] = base + 32'(4 * k);
            end
            got = 1'b0;
            n = 0;
            while (!got && n < 80) begin
                @(posedge clk); #1;
                n++;
                got = pd ? d_ack[g] : i_ack[g];
            end
            if (!got) begin
                n_cmp++;
                n_bad++;
                $display("FAIL stream_timeout_g%0d_p%0d: got no ack for item %0d expected ack within 80", g, pd, k);
            end
        end
        if (pd) d_req[g] = 1'b0;
        else    i_req[g] = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int k;
        rst = 1'b1;
        i_req = '0; i_addr = '0; d_req = '0; d_we = '0; d_addr = '0; d_wdata = '0;
        ref_reset();

        // Literal pins for the reference model itself.
        chk("ref_pin_50", 64'(ref_mem[0][8'h14]), 64'hAABBCCDD);
        chk("ref_pin_200", 64'(exp_rd(1, 1'b1, 32'h1000_0208)), 64'h5_C0DE_0082);

        // Both ports requesting from reset: inst0 alternates D,I,D,I; inst1 serves data first.
        push_exp(0, exp_rd(0, 1'b1, 32'h1000_0200));
        push_exp(0, exp_rd(0, 1'b0, 32'h0040_0100));
        push_exp(0, exp_rd(0, 1'b1, 32'h1000_0204));
        push_exp(0, exp_rd(0, 1'b0, 32'h0040_0104));
        push_exp(1, exp_rd(1, 1'b1, 32'h1000_0200));
        push_exp(1, exp_rd(1, 1'b1, 32'h1000_0204));
        push_exp(1, exp_rd(1, 1'b1, 32'h1000_0208));
        push_exp(1, exp_rd(1, 1'b0, 32'h0040_0100));
        fork
            begin repeat (3) @(posedge clk); #1 rst = 1'b0; end
            stream(0, 1'b1, 32'h1000_0200, 2);
            stream(0, 1'b0, 32'h0040_0100, 2);
            stream(1, 1'b1, 32'h1000_0200, 3);
            stream(1, 1'b0, 32'h0040_0100, 1);
        join
        repeat (2) @(posedge clk);

        // Isolated accesses on inst0 (RD_LAT=1).
        xact("fetch50", 0, 1'b0, 1'b0, 32'h0040_0050, 32'h0, 3, 1, 0);
        xact("store24", 0, 1'b1, 1'b1, 32'h1000_0024, 32'h0000_0007, 2, 1, 1);
        xact("load24", 0, 1'b1, 1'b0, 32'h1000_0024, 32'h0, 3, 1, 0);
        xact("misal26", 0, 1'b1, 1'b0, 32'h1000_0026, 32'h0, 1, 0, 0);
        xact("misal_st", 0, 1'b1, 1'b1, 32'h1000_0031, 32'h1234, 1, 0, 0);

        // Isolated accesses on inst1 (RD_LAT=3).
        xact("fetch50_l3", 1, 1'b0, 1'b0, 32'h0040_0050, 32'h0, 5, 1, 0);
        xact("store_l3", 1, 1'b1, 1'b1, 32'h1000_0040, 32'hCAFE_F00D, 2, 1, 1);
        xact("load_l3", 1, 1'b1, 1'b0, 32'h1000_0040, 32'h0, 5, 1, 0);

        // Reset while a fetch is in WAIT: the fetch is dropped and never acked.
        @(posedge clk); #1;
        i_req[0] = 1'b1;
        i_addr[0] = 32'h0040_0060;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("wait_cs", 64'(mem_cs[0]), 64'd0);
        chk("wait_oe", 64'(mem_oe[0]), 64'd1);
        chk("wait_busy", 64'(busy[0]), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", 64'(busy[0]), 64'd0);
        chk("arst_outs", 64'({i_ack[0], mem_cs[0], mem_oe[0], mem_we[0]}), 64'd0);
        chk("arst_addr", 64'(mem_addr[0]), 64'd0);
        i_req[0] = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        ref_reset();
        k = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (i_ack[0] || d_ack[0]) k++;
        end
        chk("no_ack_after_rst", 64'(k), 64'd0);
        xact("fetch_after_rst", 0, 1'b0, 1'b0, 32'h0040_0060, 32'h0, 3, 1, 0);

        repeat (3) @(posedge clk);
        chk("q0_drained", 64'(exp_q0.size()), 64'd0);
        chk("q1_drained", 64'(exp_q1.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
